// File: rtl/i2c_target_receiver.sv
// I2C target receive front end.
// Synchronizes the raw SCL/SDA pins and detects START/STOP. Shifts in the
// address byte and write-data bytes and drives ACK on SDA. Each completed
// write byte is presented with a one-cycle strobe. Matched read transactions
// are only flagged; a downstream transmitter handles their data phase.
module i2c_target_receiver #(
  parameter logic [6:0] ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       addr_match,
  output logic       rd_active,
  output logic       start_seen,
  output logic       stop_seen,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_IGNORE
  } state_t;

  // Bit 1 is SCL, bit 0 is SDA.
  logic [1:0] pin_raw;
  logic [1:0] pin_s;
  logic [1:0] pin_p;

  assign pin_raw = {scl_in, sda_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      // Two-flop synchronizer plus one history flop. All three reset high,
      // matching an idle bus, so that reset release creates no false edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          prev_reg <= 1'b1;
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign pin_s[gi] = sync_reg;
      assign pin_p[gi] = prev_reg;
    end
  endgenerate

  logic scl_s, scl_p, sda_s, sda_p;
  assign scl_s = pin_s[1];
  assign scl_p = pin_p[1];
  assign sda_s = pin_s[0];
  assign sda_p = pin_p[0];

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_ev  = scl_s & scl_p & ~sda_p & sda_s;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       rw_reg, rw_next;
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] byte_out_reg, byte_out_next;
  logic       byte_valid_reg, byte_valid_next;
  logic       addr_match_reg, addr_match_next;
  logic       rd_active_reg, rd_active_next;
  logic       start_seen_reg, start_seen_next;
  logic       stop_seen_reg, stop_seen_next;
  logic       busy_reg, busy_next;

  // The byte as it will look once the bit sampled on this rise is shifted in.
  logic [7:0] shift_in;
  assign shift_in = {shift_reg[6:0], sda_s};

  // Next-state and next-output logic; START wins over STOP and over SCL edges.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    rw_next         = rw_reg;
    sda_oe_next     = sda_oe_reg;
    byte_out_next   = byte_out_reg;
    byte_valid_next = 1'b0;
    addr_match_next = addr_match_reg;
    rd_active_next  = rd_active_reg;
    start_seen_next = 1'b0;
    stop_seen_next  = 1'b0;
    busy_next       = busy_reg;

    if (start_ev) begin
      state_next      = S_ADDR;
      bit_cnt_next    = 3'd0;
      sda_oe_next     = 1'b0;
      addr_match_next = 1'b0;
      rd_active_next  = 1'b0;
      busy_next       = 1'b1;
      start_seen_next = 1'b1;
    end else if (stop_ev) begin
      state_next      = S_IDLE;
      sda_oe_next     = 1'b0;
      addr_match_next = 1'b0;
      rd_active_next  = 1'b0;
      busy_next       = 1'b0;
      stop_seen_next  = 1'b1;
    end else begin
      case (state_reg)
        S_ADDR: begin
          if (scl_rise) begin
            shift_next = shift_in;
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next = 3'd0;
              if (shift_in[7:1] == ADDR) begin
                state_next      = S_ADDR_ACK;
                addr_match_next = 1'b1;
                rw_next         = shift_in[0];
              end else begin
                state_next = S_IGNORE;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end

        // sda_oe doubles as the ACK phase marker: the first fall starts
        // driving, the fall that ends the ACK clock releases the line.
        S_ADDR_ACK, S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 3'd0;
              if (state_reg == S_ADDR_ACK && rw_reg) begin
                state_next     = S_READ;
                rd_active_next = 1'b1;
              end else begin
                state_next = S_WRITE;
              end
            end
          end
        end

        S_WRITE: begin
          if (scl_rise) begin
            shift_next = shift_in;
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next    = 3'd0;
              byte_out_next   = shift_in;
              byte_valid_next = 1'b1;
              state_next      = S_WRITE_ACK;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end

        default: begin
          // IDLE, READ and IGNORE wait for START or STOP only.
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      rw_reg         <= 1'b0;
      sda_oe_reg     <= 1'b0;
      byte_out_reg   <= 8'h00;
      byte_valid_reg <= 1'b0;
      addr_match_reg <= 1'b0;
      rd_active_reg  <= 1'b0;
      start_seen_reg <= 1'b0;
      stop_seen_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      rw_reg         <= rw_next;
      sda_oe_reg     <= sda_oe_next;
      byte_out_reg   <= byte_out_next;
      byte_valid_reg <= byte_valid_next;
      addr_match_reg <= addr_match_next;
      rd_active_reg  <= rd_active_next;
      start_seen_reg <= start_seen_next;
      stop_seen_reg  <= stop_seen_next;
      busy_reg       <= busy_next;
    end
  end

  assign sda_oe     = sda_oe_reg;
  assign byte_out   = byte_out_reg;
  assign byte_valid = byte_valid_reg;
  assign addr_match = addr_match_reg;
  assign rd_active  = rd_active_reg;
  assign start_seen = start_seen_reg;
  assign stop_seen  = stop_seen_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Testbench for i2c_target_receiver: a bit-level I2C master drives the bus
// (SDA is wired-AND with the target's open-drain pull). Expected write bytes
// go into a queue, and a negedge monitor pops and compares them on byte_valid.
`timescale 1ns/1ps
module tb_i2c_target_receiver;
  localparam int H = 6;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_drv;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] byte_out;
  logic       byte_valid, addr_match, rd_active, start_seen, stop_seen, busy;

  assign sda_line = sda_drv & ~sda_oe;

  i2c_target_receiver #(.ADDR(7'h2A)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .addr_match(addr_match),
    .rd_active (rd_active),
    .start_seen(start_seen),
    .stop_seen (stop_seen),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int ack_seen = 0, ack_exp = 0;
  int start_cnt = 0, start_exp = 0, stop_cnt = 0, stop_exp = 0;
  logic oe_prev = 1'b0, bv_prev = 1'b0, ss_prev = 1'b0, sp_prev = 1'b0;
  logic [7:0] txn_data [0:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on byte_valid, counts pulses and ACK assertions.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      oe_prev = 1'b0;
      bv_prev = 1'b0;
      ss_prev = 1'b0;
      sp_prev = 1'b0;
    end else begin
      if (byte_valid) begin
        chk("byte_valid_single", {31'd0, bv_prev}, 0);
        chk("byte_valid_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("byte_out", {24'd0, byte_out}, {24'd0, e});
          $display("byte received %02h", byte_out);
        end
      end
      if (start_seen) begin
        chk("start_single", {31'd0, ss_prev}, 0);
        start_cnt++;
      end
      if (stop_seen) begin
        chk("stop_single", {31'd0, sp_prev}, 0);
        stop_cnt++;
      end
      if (sda_oe && !oe_prev) ack_seen++;
      oe_prev = sda_oe;
      bv_prev = byte_valid;
      ss_prev = start_seen;
      sp_prev = stop_seen;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    sda_drv = b;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    scl = 1'b0;
    wait_clk(2);
  endtask

  // Eight data bits then the ACK clock; at the ACK rise the target's pull
  // must match what the reference says.
  task automatic send_byte(input logic [7:0] b, input bit exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1;
    wait_clk(H);
    scl = 1'b1;
    chk("ack_drive", {31'd0, sda_oe}, {31'd0, exp_ack});
    wait_clk(H);
    scl = 1'b0;
    wait_clk(4);
  endtask

  // START (or repeated START): SDA falls while SCL is high. The pulse must
  // appear on the third negedge after the SDA change.
  task automatic do_start();
    sda_drv = 1'b1;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    sda_drv = 1'b0;
    start_exp++;
    wait_clk(2);
    chk("start_early", {31'd0, start_seen}, 0);
    wait_clk(1);
    chk("start_latency", {31'd0, start_seen}, 1);
    wait_clk(H);
    chk("busy_after_start", {31'd0, busy}, 1);
    scl = 1'b0;
    wait_clk(H);
  endtask

  task automatic do_stop();
    sda_drv = 1'b0;
    wait_clk(H);
    scl = 1'b1;
    wait_clk(H);
    sda_drv = 1'b1;
    stop_exp++;
    wait_clk(3);
    chk("stop_latency", {31'd0, stop_seen}, 1);
    wait_clk(H);
    chk("busy_after_stop", {31'd0, busy}, 0);
    chk("addr_match_after_stop", {31'd0, addr_match}, 0);
    chk("rd_active_after_stop", {31'd0, rd_active}, 0);
  endtask

  // One transaction with nd full data bytes from txn_data. Reference:
  // the target answers only 0x2A; a matched write ACKs and reports every
  // data byte; a matched read ACKs only its address.
  task automatic run_txn(input logic [7:0] a, input int nd, input bit end_stop);
    bit hit, rd;
    hit = (a[7:1] == 7'h2A);
    rd  = a[0];
    $display("txn addr=%02h bytes=%0d stop=%0d hit=%0d", a, nd, end_stop, hit);
    do_start();
    if (hit) ack_exp++;
    send_byte(a, hit);
    chk("addr_match", {31'd0, addr_match}, {31'd0, hit});
    for (int k = 0; k < nd; k++) begin
      if (hit && !rd) begin
        exp_q.push_back(txn_data[k]);
        ack_exp++;
      end
      send_byte(txn_data[k], hit && !rd);
    end
    chk("rd_active", {31'd0, rd_active}, {31'd0, hit && rd});
    chk("busy_mid", {31'd0, busy}, 1);
    chk("ack_count", ack_seen, ack_exp);
    if (end_stop) do_stop();
  endtask

  initial begin
    logic [7:0] part;
    logic [7:0] a;
    int nd;
    bit st;

    reset = 1'b1;
    scl = 1'b1;
    sda_drv = 1'b1;
    wait_clk(3);
    chk("reset_sda_oe", {31'd0, sda_oe}, 0);
    chk("reset_byte_out", {24'd0, byte_out}, 0);
    chk("reset_flags", {26'd0, byte_valid, addr_match, rd_active, start_seen, stop_seen, busy}, 0);
    reset = 1'b0;
    wait_clk(20);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_sda_oe", {31'd0, sda_oe}, 0);

    // Matched write of 0xA5.
    txn_data[0] = 8'hA5;
    run_txn(8'h54, 1, 1'b1);
    // Address 0x15: ignored entirely.
    txn_data[0] = 8'hFF;
    run_txn(8'h2A, 1, 1'b1);
    // Matched read: rd_active, no bytes for 9 further clocks.
    txn_data[0] = 8'h00;
    run_txn(8'h55, 1, 1'b1);

    // Partial write byte aborted by a repeated START.
    $display("txn partial 0x3C then repeated start");
    do_start();
    ack_exp++;
    send_byte(8'h54, 1'b1);
    part = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(part[i]);
    txn_data[0] = 8'h81;
    run_txn(8'h54, 1, 1'b1);

    // Reset while the target is pulling SDA for a write ACK.
    $display("txn reset during write ack");
    do_start();
    ack_exp++;
    send_byte(8'h54, 1'b1);
    part = 8'h6E;
    exp_q.push_back(part);
    for (int i = 7; i >= 0; i--) send_bit(part[i]);
    sda_drv = 1'b1;
    wait_clk(2);
    chk("pre_reset_ack", {31'd0, sda_oe}, 1);
    ack_exp++;
    reset = 1'b1;
    wait_clk(1);
    chk("reset_mid_sda_oe", {31'd0, sda_oe}, 0);
    chk("reset_mid_flags", {26'd0, byte_valid, addr_match, rd_active, start_seen, stop_seen, busy}, 0);
    reset = 1'b0;
    part = 8'hC3;
    for (int i = 7; i >= 0; i--) send_bit(part[i]);
    send_bit(1'b1);
    chk("post_reset_busy", {31'd0, busy}, 0);
    chk("post_reset_acks", ack_seen, ack_exp);
    txn_data[0] = 8'h5A;
    run_txn(8'h54, 1, 1'b1);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 3))
        0: a = 8'h54;
        1: a = 8'h55;
        2: a = 8'($urandom_range(0, 255));
        default: a = 8'h54;
      endcase
      nd = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) txn_data[k] = 8'($urandom_range(0, 255));
      st = (t == 19) ? 1'b1 : 1'($urandom_range(0, 1));
      run_txn(a, nd, st);
    end

    wait_clk(10);
    chk("queue_drained", exp_q.size(), 0);
    chk("start_count", start_cnt, start_exp);
    chk("stop_count", stop_cnt, stop_exp);
    chk("ack_total", ack_seen, ack_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500us;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
